hs_ram_responder: RTL and testbench

Responder end of the hiscore RAM access channel inside the game top. It takes the hiscore engine's address/data/write/access requests and arbitrates the single port of the Z80 work-RAM block between the CPU and the hiscore engine. Ownership passes to the hiscore side only while the CPU is paused. Read data is returned at a fixed latency so the initiator can run without a ready signal.

---
 rtl/hs_pkg.sv | 15 +
 rtl/hs_addr_window.sv | 18 +
 rtl/hs_ram_responder.sv | 159 +++++++++++++++
 tb/tb_hs_ram_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared constants and state encoding for the hiscore RAM access channel.
package hs_pkg;

    localparam int unsigned HS_ADDR_W   = 16;
    localparam int unsigned HS_DATA_W   = 8;
    localparam int unsigned HS_READ_LAT = 3;

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_GUARD   = 2'd1,
        ST_HS      = 2'd2,
        ST_RELEASE = 2'd3
    } hs_state_e;

endpackage : hs_pkg

// File: rtl/hs_addr_window.sv
// Maps a hiscore CPU-space address onto the work-RAM window.
module hs_addr_window
    import hs_pkg::*;
#(
    parameter int unsigned           RAM_AW   = 12,
    parameter logic [HS_ADDR_W-1:0]  RAM_BASE = 16'h6000,
    parameter logic [HS_ADDR_W-1:0]  RAM_LAST = 16'h6BFF
) (
    input  logic [HS_ADDR_W-1:0] i_addr,
    output logic [RAM_AW-1:0]    o_offset,
    output logic                 o_in_range
);

    // 16-bit subtraction, truncated to the RAM address width.
    assign o_offset   = RAM_AW'(i_addr - RAM_BASE);
    assign o_in_range = (i_addr >= RAM_BASE) && (i_addr <= RAM_LAST);

endmodule : hs_addr_window

// File: rtl/hs_ram_responder.sv
// Arbitrates the work-RAM port between the CPU and the hiscore engine.
// The hiscore side owns the port only while the CPU is paused; read data
// returns at a fixed latency so the initiator needs no ready handshake.
module hs_ram_responder
    import hs_pkg::*;
#(
    parameter int unsigned           RAM_AW   = 12,
    parameter logic [HS_ADDR_W-1:0]  RAM_BASE = 16'h6000,
    parameter logic [HS_ADDR_W-1:0]  RAM_LAST = 16'h6BFF
) (
    input  logic                 I_CLK_24576M,
    input  logic                 I_RESETn,
    input  logic [HS_ADDR_W-1:0] hs_address,
    input  logic [HS_DATA_W-1:0] hs_data_in,
    output logic [HS_DATA_W-1:0] hs_data_out,
    input  logic                 hs_write,
    input  logic                 hs_access,
    input  logic                 cpu_paused,
    input  logic [RAM_AW-1:0]    cpu_addr,
    input  logic [HS_DATA_W-1:0] cpu_din,
    input  logic                 cpu_we,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [HS_DATA_W-1:0] ram_din,
    output logic                 ram_we,
    input  logic [HS_DATA_W-1:0] ram_dout,
    output logic                 hs_owner,
    output logic                 hs_oor
);

    hs_state_e              r_state;
    logic                   r_hs_owner;
    logic [HS_ADDR_W-1:0]   r_addr_q;
    logic [HS_DATA_W-1:0]   r_din_q;
    logic                   r_we_q;
    logic                   r_rd_ok;
    logic [HS_DATA_W-1:0]   r_data_out;
    logic                   r_oor;

    logic [RAM_AW-1:0]      w_offset;
    logic                   w_in_range;

    // Range check and offset of the captured hiscore address.
    hs_addr_window #(
        .RAM_AW   (RAM_AW),
        .RAM_BASE (RAM_BASE),
        .RAM_LAST (RAM_LAST)
    ) u_addr_window (
        .i_addr     (r_addr_q),
        .o_offset   (w_offset),
        .o_in_range (w_in_range)
    );

    // Capture the hiscore request every cycle regardless of ownership.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_addr_q <= '0;
            r_din_q  <= '0;
            r_we_q   <= 1'b0;
        end else begin
            r_addr_q <= hs_address;
            r_din_q  <= hs_data_in;
            r_we_q   <= hs_write;
        end
    end

    // Ownership FSM; losing the pause always wins and returns the port at once.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_state    <= ST_CPU;
            r_hs_owner <= 1'b0;
        end else begin
            case (r_state)
                ST_CPU: begin
                    r_hs_owner <= 1'b0;
                    if (hs_access && cpu_paused) begin
                        r_state <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (hs_access && cpu_paused) begin
                        r_state    <= ST_HS;
                        r_hs_owner <= 1'b1;
                    end else begin
                        r_state    <= ST_CPU;
                        r_hs_owner <= 1'b0;
                    end
                end
                ST_HS: begin
                    if (!cpu_paused) begin
                        r_state    <= ST_CPU;
                        r_hs_owner <= 1'b0;
                    end else if (!hs_access) begin
                        r_state    <= ST_RELEASE;
                        r_hs_owner <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    r_state    <= ST_CPU;
                    r_hs_owner <= 1'b0;
                end
                default: begin
                    r_state    <= ST_CPU;
                    r_hs_owner <= 1'b0;
                end
            endcase
        end
    end

    // Read return: remember whether the RAM read was a valid hiscore read,
    // then register its data (or zero) one cycle later while still in HS.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_rd_ok    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_rd_ok <= (r_state == ST_HS) && w_in_range;
            if (r_state == ST_HS) begin
                r_data_out <= r_rd_ok ? ram_dout : '0;
            end
        end
    end

    // Sticky flag for hiscore writes that fall outside the window.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            r_oor <= 1'b0;
        end else if ((r_state == ST_HS) && r_we_q && !w_in_range) begin
            r_oor <= 1'b1;
        end
    end

    // RAM port mux; writes are suppressed outside CPU/HS and during abort.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        case (r_state)
            ST_CPU: begin
                ram_we = cpu_we;
            end
            ST_HS: begin
                ram_addr = w_offset;
                ram_din  = r_din_q;
                ram_we   = r_we_q && w_in_range && cpu_paused;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
        if (!I_RESETn) begin
            ram_we = 1'b0;
        end
    end

    assign hs_data_out = r_data_out;
    assign hs_owner    = r_hs_owner;
    assign hs_oor      = r_oor;

endmodule : hs_ram_responder

// File: tb/tb_hs_ram_responder.sv
// Directed bench for hs_ram_responder with a behavioural 4 KB sync RAM.
module tb_hs_ram_responder;
    import hs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hs_address = '0;
    logic [7:0]  hs_data_in = '0;
    logic [7:0]  hs_data_out;
    logic        hs_write = 1'b0;
    logic        hs_access = 1'b1;
    logic        cpu_paused = 1'b1;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_we = 1'b0;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout = '0;
    logic        hs_owner;
    logic        hs_oor;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [4096];
    logic       loaded = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic [11:0] exp_ram_addr;
        logic [7:0]  exp_data;
    } rd_vec_t;

    rd_vec_t vec [7];

    always #5 clk = ~clk;

    hs_ram_responder dut (
        .I_CLK_24576M (clk),
        .I_RESETn     (rst_n),
        .hs_address   (hs_address),
        .hs_data_in   (hs_data_in),
        .hs_data_out  (hs_data_out),
        .hs_write     (hs_write),
        .hs_access    (hs_access),
        .cpu_paused   (cpu_paused),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_we       (cpu_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_dout     (ram_dout),
        .hs_owner     (hs_owner),
        .hs_oor       (hs_oor)
    );

    // Sync RAM model, read-before-write, preloaded on the first edge.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) begin
                mem[i] <= 8'hC3;
            end
            mem[12'h000] <= 8'h11;
            mem[12'h010] <= 8'hA5;
            mem[12'h020] <= 8'hD2;
            mem[12'h030] <= 8'hC3;
            mem[12'h200] <= 8'hB7;
            mem[12'h800] <= 8'h6E;
            mem[12'hBFF] <= 8'h00;
            loaded <= 1'b1;
        end else begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
            end
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev_data;

        vec[0] = '{16'h6000, 12'h000, 8'h11};
        vec[1] = '{16'h6010, 12'h010, 8'hA5};
        vec[2] = '{16'h6800, 12'h800, 8'h6E};
        vec[3] = '{16'h5FFF, 12'hFFF, 8'h00};
        vec[4] = '{16'h6C00, 12'hC00, 8'h00};
        vec[5] = '{16'hFFFF, 12'hFFF, 8'h00};
        vec[6] = '{16'h6BFE, 12'hBFE, 8'hC3};

        // Reset held with a pending, permitted hiscore request.
        repeat (3) tick();
        chk("rst_owner", 32'(hs_owner), 32'h0);
        chk("rst_data", 32'(hs_data_out), 32'h0);
        chk("rst_oor", 32'(hs_oor), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("owner_edge1", 32'(hs_owner), 32'h0);
        tick();
        chk("owner_edge2", 32'(hs_owner), 32'h1);
        tick();
        chk("data_before_read", 32'(hs_data_out), 32'h0);

        // Read with exact latency.
        hs_address = 16'h6010;
        tick();
        chk("rd_ram_addr", 32'(ram_addr), 32'h010);
        chk("rd_ram_we", 32'(ram_we), 32'h0);
        tick();
        chk("rd_lat_minus1", 32'(hs_data_out), 32'h00);
        tick();
        chk("rd_lat", 32'(hs_data_out), 32'hA5);

        // Write to last legal address, then read it back.
        hs_address = 16'h6BFF;
        hs_data_in = 8'h3C;
        hs_write   = 1'b1;
        tick();
        chk("wr_we", 32'(ram_we), 32'h1);
        chk("wr_addr", 32'(ram_addr), 32'hBFF);
        chk("wr_din", 32'(ram_din), 32'h3C);
        hs_write = 1'b0;
        repeat (HS_READ_LAT) tick();
        chk("wr_readback", 32'(hs_data_out), 32'h3C);

        // Read table across window boundaries.
        prev_data = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            hs_address = vec[i].addr;
            tick();
            chk($sformatf("tbl%0d_ram_addr", i), 32'(ram_addr), 32'(vec[i].exp_ram_addr));
            tick();
            chk($sformatf("tbl%0d_hold", i), 32'(hs_data_out), 32'(prev_data));
            tick();
            chk($sformatf("tbl%0d_data", i), 32'(hs_data_out), 32'(vec[i].exp_data));
            prev_data = vec[i].exp_data;
        end
        chk("oor_after_reads", 32'(hs_oor), 32'h0);

        // Out-of-range write is dropped and flagged; its read returns zero.
        hs_address = 16'h7000;
        hs_data_in = 8'h77;
        hs_write   = 1'b1;
        tick();
        chk("oor_we", 32'(ram_we), 32'h0);
        hs_write = 1'b0;
        tick();
        chk("oor_flag", 32'(hs_oor), 32'h1);
        tick();
        chk("oor_read", 32'(hs_data_out), 32'h00);

        // Pause lost mid-write: abort straight back to the CPU.
        hs_address = 16'h6020;
        hs_data_in = 8'h99;
        hs_write   = 1'b1;
        tick();
        chk("abort_pre_we", 32'(ram_we), 32'h1);
        cpu_paused = 1'b0;
        cpu_addr   = 12'h123;
        cpu_din    = 8'h44;
        cpu_we     = 1'b1;
        #1;
        chk("abort_cycle_we", 32'(ram_we), 32'h0);
        tick();
        chk("abort_owner", 32'(hs_owner), 32'h0);
        chk("abort_addr", 32'(ram_addr), 32'h123);
        chk("abort_din", 32'(ram_din), 32'h44);
        chk("abort_cpu_we", 32'(ram_we), 32'h1);
        hs_write = 1'b0;
        tick();
        cpu_we = 1'b0;

        // GUARD blocks a CPU write.
        hs_access  = 1'b0;
        cpu_paused = 1'b1;
        tick();
        hs_access = 1'b1;
        tick();
        chk("guard_owner", 32'(hs_owner), 32'h0);
        cpu_addr = 12'h200;
        cpu_din  = 8'hEE;
        cpu_we   = 1'b1;
        #1;
        chk("guard_we", 32'(ram_we), 32'h0);
        chk("guard_addr", 32'(ram_addr), 32'h200);
        tick();
        chk("guard_to_hs", 32'(hs_owner), 32'h1);

        // RELEASE: one cycle with writes blocked, then CPU.
        cpu_addr  = 12'h300;
        cpu_din   = 8'h5A;
        hs_access = 1'b0;
        tick();
        chk("rel_owner", 32'(hs_owner), 32'h0);
        chk("rel_we", 32'(ram_we), 32'h0);
        chk("rel_addr", 32'(ram_addr), 32'h300);
        tick();
        chk("rel_to_cpu_we", 32'(ram_we), 32'h1);
        cpu_we = 1'b0;

        // Simultaneous drop of access and pause takes the abort path.
        hs_access = 1'b1;
        tick();
        tick();
        chk("sim_in_hs", 32'(hs_owner), 32'h1);
        hs_access  = 1'b0;
        cpu_paused = 1'b0;
        cpu_addr   = 12'h301;
        cpu_we     = 1'b1;
        tick();
        chk("sim_owner", 32'(hs_owner), 32'h0);
        chk("sim_cpu_we", 32'(ram_we), 32'h1);
        cpu_we = 1'b0;

        // Reset in the middle of an HS write.
        hs_access  = 1'b1;
        cpu_paused = 1'b1;
        tick();
        tick();
        hs_address = 16'h6030;
        hs_data_in = 8'h55;
        hs_write   = 1'b1;
        tick();
        chk("mrst_pre_we", 32'(ram_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mrst_we", 32'(ram_we), 32'h0);
        chk("mrst_owner", 32'(hs_owner), 32'h0);
        chk("mrst_oor", 32'(hs_oor), 32'h0);
        chk("mrst_data", 32'(hs_data_out), 32'h0);
        hs_write = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_reacquire", 32'(hs_owner), 32'h1);

        // RAM contents after the sequence.
        chk("mem_oor_dropped", 32'(mem[12'h000]), 32'h11);
        chk("mem_abort_no_wr", 32'(mem[12'h020]), 32'hD2);
        chk("mem_guard_no_wr", 32'(mem[12'h200]), 32'hB7);
        chk("mem_cpu_wr", 32'(mem[12'h123]), 32'h44);
        chk("mem_mrst_no_wr", 32'(mem[12'h030]), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hs_ram_responder
